// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I hart: per-stage stall/flush controls,
// fetch enable, halt/trap drain sequencing and saturating stall/flush counters.
module pipe_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load_use,
  input  logic             i_flush_req,
  input  logic             i_imem_busy,
  input  logic             i_dmem_busy,
  input  logic             i_id_valid,
  input  logic             i_id_halt,
  input  logic             i_id_trap,
  input  logic             i_wb_valid,
  input  logic             i_wb_halt,
  output logic             o_fetch_en,
  output logic             o_if_stall,
  output logic             o_id_stall,
  output logic             o_ex_stall,
  output logic             o_mem_stall,
  output logic             o_id_flush,
  output logic             o_ex_flush,
  output logic             o_halted,
  output logic             o_trap,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam logic [1:0] BOOT   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             trap_q, trap_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             flush_acc;
  logic             stall_inc;

  always_comb begin
    o_fetch_en  = 1'b0;
    o_if_stall  = 1'b0;
    o_id_stall  = 1'b0;
    o_ex_stall  = 1'b0;
    o_mem_stall = 1'b0;
    o_id_flush  = 1'b0;
    o_ex_flush  = 1'b0;
    flush_acc   = 1'b0;
    state_d     = state_q;
    trap_d      = trap_q;
    halted_d    = halted_q;

    case (state_q)
      BOOT: begin
        o_if_stall  = 1'b1;
        o_id_stall  = 1'b1;
        o_ex_stall  = 1'b1;
        o_mem_stall = 1'b1;
        o_id_flush  = 1'b1;
        o_ex_flush  = 1'b1;
        state_d     = RUN;
      end
      RUN, DRAIN: begin
        if (i_dmem_busy) begin
          o_if_stall  = 1'b1;
          o_id_stall  = 1'b1;
          o_ex_stall  = 1'b1;
          o_mem_stall = 1'b1;
        end else if (i_flush_req) begin
          // Redirect; in DRAIN this means the halt was on the wrong path.
          o_id_flush = 1'b1;
          o_ex_flush = 1'b1;
          o_fetch_en = 1'b1;
          flush_acc  = 1'b1;
          if (state_q == DRAIN) begin
            state_d = RUN;
            trap_d  = 1'b0;
          end
        end else if (i_load_use) begin
          o_if_stall = 1'b1;
          o_id_stall = 1'b1;
          o_ex_flush = 1'b1;
        end else if (state_q == RUN) begin
          if (i_imem_busy) begin
            o_if_stall = 1'b1;
            o_id_flush = 1'b1;
          end else begin
            o_fetch_en = 1'b1;
          end
          if (i_id_valid && (i_id_halt || i_id_trap)) begin
            state_d = DRAIN;
            trap_d  = i_id_trap;
          end
        end else begin
          o_if_stall = 1'b1;
          o_id_flush = 1'b1;
        end

        if (state_q == DRAIN && !i_dmem_busy && !i_flush_req && i_wb_valid && i_wb_halt) begin
          state_d  = HALTED;
          halted_d = 1'b1;
        end
      end
      default: begin
        o_if_stall  = 1'b1;
        o_id_stall  = 1'b1;
        o_ex_stall  = 1'b1;
        o_mem_stall = 1'b1;
      end
    endcase
  end

  assign stall_inc = ((state_q == RUN) || (state_q == DRAIN)) && o_if_stall;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= BOOT;
      trap_q      <= 1'b0;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      trap_q   <= trap_d;
      halted_q <= halted_d;
      if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_acc && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign o_state     = state_q;
  assign o_trap      = trap_q;
  assign o_halted    = halted_q;
  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a driver feeds directed and random hazard patterns
// through a reference model; a monitor compares DUT outputs every cycle.
module tb_pipe_ctrl;

  localparam int unsigned W = 6;
  localparam logic [W-1:0] SAT = {W{1'b1}};

  typedef struct packed {
    logic load_use, flush_req, imem_busy, dmem_busy;
    logic id_valid, id_halt, id_trap, wb_valid, wb_halt;
  } in_t;

  typedef struct packed {
    logic fetch_en, if_s, id_s, ex_s, mem_s, id_f, ex_f, halted, trap;
    logic [1:0] state;
    logic [W-1:0] stall_cnt, flush_cnt;
  } exp_t;

  typedef enum {MBoot, MRun, MDrain, MHalted} mstate_e;
  typedef enum {ABoot, AHalted, AFreeze, ARedirect, ALoadUse, AFetchWait, AGo, ADrain} act_e;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  in_t  in = '0;

  logic fetch_en, if_stall, id_stall, ex_stall, mem_stall, id_flush, ex_flush, halted, trap;
  logic [1:0]   state;
  logic [W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(W)) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_load_use  (in.load_use),
    .i_flush_req (in.flush_req),
    .i_imem_busy (in.imem_busy),
    .i_dmem_busy (in.dmem_busy),
    .i_id_valid  (in.id_valid),
    .i_id_halt   (in.id_halt),
    .i_id_trap   (in.id_trap),
    .i_wb_valid  (in.wb_valid),
    .i_wb_halt   (in.wb_halt),
    .o_fetch_en  (fetch_en),
    .o_if_stall  (if_stall),
    .o_id_stall  (id_stall),
    .o_ex_stall  (ex_stall),
    .o_mem_stall (mem_stall),
    .o_id_flush  (id_flush),
    .o_ex_flush  (ex_flush),
    .o_halted    (halted),
    .o_trap      (trap),
    .o_state     (state),
    .o_stall_cnt (stall_cnt),
    .o_flush_cnt (flush_cnt)
  );

  // Reference model state
  mstate_e m_st = MBoot;
  logic    m_trap = 1'b0, m_halted = 1'b0;
  int      m_stalls = 0, m_flushes = 0;

  exp_t exp_q[$];
  string name_q[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic act_e pick_action(in_t x);
    if (m_st == MBoot)   return ABoot;
    if (m_st == MHalted) return AHalted;
    if (x.dmem_busy)     return AFreeze;
    if (x.flush_req)     return ARedirect;
    if (x.load_use)      return ALoadUse;
    if (m_st == MDrain)  return ADrain;
    return x.imem_busy ? AFetchWait : AGo;
  endfunction

  function automatic logic [W-1:0] sat(int v);
    return (v > int'(SAT)) ? SAT : W'(v);
  endfunction

  // Drive one cycle: apply inputs at negedge, queue expected response, advance model.
  task automatic step(input logic rst, input in_t x, input string nm);
    exp_t e;
    act_e a;
    @(negedge clk);
    rst_n = rst;
    in    = x;
    if (!rst) begin
      m_st = MBoot; m_trap = 1'b0; m_halted = 1'b0; m_stalls = 0; m_flushes = 0;
    end
    a = pick_action(x);
    e = '0;
    case (a)
      ABoot:      {e.if_s, e.id_s, e.ex_s, e.mem_s, e.id_f, e.ex_f} = 6'b111111;
      AHalted:    {e.if_s, e.id_s, e.ex_s, e.mem_s} = 4'b1111;
      AFreeze:    {e.if_s, e.id_s, e.ex_s, e.mem_s} = 4'b1111;
      ARedirect:  {e.id_f, e.ex_f, e.fetch_en} = 3'b111;
      ALoadUse:   {e.if_s, e.id_s, e.ex_f} = 3'b111;
      AFetchWait: {e.if_s, e.id_f} = 2'b11;
      AGo:        e.fetch_en = 1'b1;
      default:    {e.if_s, e.id_f} = 2'b11;
    endcase
    e.halted    = m_halted;
    e.trap      = m_trap;
    e.state     = 2'(int'(m_st));
    e.stall_cnt = sat(m_stalls);
    e.flush_cnt = sat(m_flushes);
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (!rst) return;
    if ((m_st == MRun || m_st == MDrain) && e.if_s) m_stalls++;
    if (a == ARedirect) m_flushes++;
    case (m_st)
      MBoot: m_st = MRun;
      MRun:
        if (a != AFreeze && a != ARedirect && a != ALoadUse && x.id_valid && (x.id_halt || x.id_trap)) begin
          m_st = MDrain; m_trap = x.id_trap;
        end
      MDrain:
        if (a == ARedirect) begin
          m_st = MRun; m_trap = 1'b0;
        end else if (a != AFreeze && x.wb_valid && x.wb_halt) begin
          m_st = MHalted; m_halted = 1'b1;
        end
      default: ;
    endcase
  endtask

  // Monitor: every cycle the DUT presents its combinational response shortly after the drive.
  initial begin
    exp_t act, e;
    string nm;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        act = {fetch_en, if_stall, id_stall, ex_stall, mem_stall, id_flush, ex_flush, halted, trap,
               state, stall_cnt, flush_cnt};
        vectors++;
        if (act !== e) begin
          miscompares++;
          $display("FAIL %s t=%0t got fe%b st%b%b%b%b fl%b%b h%b tr%b s%0d sc%0d fc%0d want fe%b st%b%b%b%b fl%b%b h%b tr%b s%0d sc%0d fc%0d",
                   nm, $time, act.fetch_en, act.if_s, act.id_s, act.ex_s, act.mem_s, act.id_f, act.ex_f,
                   act.halted, act.trap, act.state, act.stall_cnt, act.flush_cnt,
                   e.fetch_en, e.if_s, e.id_s, e.ex_s, e.mem_s, e.id_f, e.ex_f,
                   e.halted, e.trap, e.state, e.stall_cnt, e.flush_cnt);
        end
      end
    end
  end

  function automatic in_t mk(logic lu, logic fl, logic im, logic dm, logic v, logic h, logic t,
                             logic wv, logic wh);
    in_t r;
    r = {lu, fl, im, dm, v, h, t, wv, wh};
    return r;
  endfunction

  function automatic logic chance(int unsigned pct);
    return $urandom_range(99) < pct;
  endfunction

  task automatic random_episode(input int cycles, input logic allow_halt);
    in_t x;
    step(1'b0, '0, "rand_reset");
    for (int c = 0; c < cycles; c++) begin
      x.dmem_busy = chance(12);
      x.flush_req = chance(25);
      x.load_use  = chance(20);
      x.imem_busy = chance(25);
      x.id_valid  = chance(70);
      x.id_halt   = allow_halt && chance(3);
      x.id_trap   = allow_halt && chance(2);
      x.wb_valid  = chance(60);
      x.wb_halt   = chance(8);
      // A halt retiring at WB excludes an older-path redirect or a frozen MEM stage.
      if (m_st == MDrain && x.wb_valid && x.wb_halt) begin
        x.flush_req = 1'b0;
        x.dmem_busy = 1'b0;
      end
      step(1'b1, x, "random");
    end
  endtask

  localparam in_t IDLE = '0;

  initial begin
    // Reset and boot
    step(1'b0, IDLE, "reset");
    step(1'b0, IDLE, "reset_hold");
    for (int i = 0; i < 4; i++) step(1'b1, IDLE, "boot_run");
    // Load-use alone, then load-use with a flush
    step(1'b1, mk(1, 0, 0, 0, 1, 0, 0, 0, 0), "load_use");
    step(1'b1, IDLE, "after_load_use");
    step(1'b1, mk(1, 1, 0, 0, 1, 0, 0, 0, 0), "flush_over_load_use");
    step(1'b1, mk(0, 1, 1, 0, 1, 1, 0, 0, 0), "flush_squash_halt");
    step(1'b1, IDLE, "after_flush");
    // Data-memory busy holds a pending flush for three cycles
    for (int i = 0; i < 3; i++) step(1'b1, mk(0, 1, 0, 1, 1, 0, 0, 0, 0), "dmem_freeze");
    step(1'b1, mk(0, 1, 0, 0, 1, 0, 0, 0, 0), "flush_after_freeze");
    step(1'b1, IDLE, "after_freeze");
    // Halt: drain three cycles, retire halt, then stay halted
    step(1'b1, mk(0, 0, 0, 0, 1, 1, 0, 0, 0), "halt_enter");
    for (int i = 0; i < 3; i++) step(1'b1, mk(0, 0, 0, 0, 1, 0, 0, 1, 0), "drain");
    step(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 1, 1), "wb_halt");
    for (int i = 0; i < 3; i++) step(1'b1, mk(1, 1, 1, 1, 1, 1, 1, 1, 1), "halted_frozen");
    // Mid-operation reset, illegal opcode, then wrong-path recovery
    step(1'b0, mk(0, 1, 0, 0, 0, 0, 0, 0, 0), "reset_mid");
    step(1'b1, IDLE, "boot2");
    step(1'b1, mk(0, 0, 1, 0, 1, 0, 1, 0, 0), "trap_enter");
    step(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "trap_drain");
    step(1'b1, mk(0, 1, 0, 0, 0, 0, 0, 0, 0), "trap_wrong_path");
    step(1'b1, IDLE, "after_trap_recover");
    // Long halt-free run drives both counters into saturation
    random_episode(600, 1'b0);
    for (int ep = 0; ep < 6; ep++) random_episode(300, 1'b1);
    step(1'b0, IDLE, "final_reset");
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_queue got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage RV32I hart. It collects the hazard and event sources and drives per-stage stall and bubble-insert (flush) controls, the fetch enable, and halt/trap drain sequencing:
- load-use stall from decode
- taken-branch/jump flush from execute
- instruction/data memory busy
- halt/illegal opcode from decode

It sits beside decode/execute in the hart top level, replacing ad-hoc stall/flush wiring, and keeps stall/flush performance counters.

Parameters:
CNT_W, 32, width of the saturating stall and flush performance counters.

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rst  in  1  reset, asynchronous, active-low
i_load_use  in  1  load-use hazard from decode (stall_pipeline)
i_flush_req  in  1  taken branch/jump resolved in execute this cycle
i_imem_busy  in  1  instruction fetch not yet returned this cycle
i_dmem_busy  in  1  data access in MEM stage not yet complete this cycle
i_id_valid  in  1  decode stage holds a valid instruction
i_id_halt  in  1  decode stage instruction is halt (opcode 1110011)
i_id_trap  in  1  decode stage instruction is illegal (decode_trap)
i_wb_valid  in  1  writeback retiring a valid instruction
i_wb_halt  in  1  retiring instruction is the halt/trap instruction
o_fetch_en  out  1  fetch may advance PC / issue new fetch
o_if_stall  out  1  hold PC and IF/ID register
o_id_stall  out  1  hold ID/EX register inputs (decode instruction held)
o_ex_stall  out  1  hold EX/MEM register
o_mem_stall  out  1  hold MEM/WB register
o_id_flush  out  1  load bubble into IF/ID (valid=0)
o_ex_flush  out  1  load bubble into ID/EX (valid=0)
o_halted  out  1  core halted, sticky until reset
o_trap  out  1  halt caused by illegal opcode, sticky until reset
o_state  out  2  FSM state (BOOT=0, RUN=1, DRAIN=2, HALTED=3)
o_stall_cnt  out  CNT_W  cycles with o_if_stall=1 in RUN/DRAIN, saturating
o_flush_cnt  out  CNT_W  accepted flush requests, saturating

Behaviour:
Structure:
- State and counters are registered; all stall/flush/fetch outputs are combinational from current state and inputs (zero-cycle latency).
- Reset asserted: state=BOOT, counters=0, o_halted=0, o_trap=0. All stalls=1, flushes=1, o_fetch_en=0.

BOOT:
- All stalls=1, both flushes=1, o_fetch_en=0 for exactly one cycle after reset release, then RUN.

RUN, priority high to low (first match wins, others ignored that cycle):
1. i_dmem_busy: all four stalls=1, flushes=0, fetch_en=0. The pending flush/load-use is re-evaluated next cycle; execute holds i_flush_req while EX is frozen.
2. i_flush_req: stalls=0, o_id_flush=1, o_ex_flush=1, fetch_en=1 (redirect). o_flush_cnt+1. Overrides load-use and imem busy; halt/trap in ID is squashed and ignored.
3. i_load_use: o_if_stall=1, o_id_stall=1, o_ex_flush=1, others 0, fetch_en=0.
4. i_imem_busy: o_if_stall=1, o_id_flush=1, others 0, fetch_en=0.
5. Otherwise: all 0, fetch_en=1.

Halt/trap entry:
- Condition: RUN, i_id_valid & (i_id_halt | i_id_trap), and no rule 1-3 active.
- The halt advances normally this cycle; next state=DRAIN. o_trap<=i_id_trap.

DRAIN:
- fetch_en=0, o_if_stall=1, o_id_flush=1 every cycle, so only bubbles follow the halt.
- Rules 1-3 still apply to older instructions (dmem busy freezes all).
- i_flush_req in DRAIN: the halt was wrong-path. Clear o_trap, return to RUN, apply rule 2 output this cycle.
- i_wb_valid & i_wb_halt: next state HALTED, o_halted<=1.

HALTED:
- All stalls=1, flushes=0, fetch_en=0. All inputs ignored. Counters frozen. Exit only via reset.

Counters:
- Saturate at all-ones, no wrap.
- o_stall_cnt counts cycles in RUN/DRAIN with o_if_stall=1.
- Reset mid-operation clears everything asynchronously regardless of state.

Test Plan:
- Reset release, no hazards -> o_state 0 for 1 cycle then 1; o_fetch_en=1 from cycle 2; all stalls/flushes 0.
- i_load_use=1 for 1 cycle -> o_if_stall=o_id_stall=o_ex_flush=1, fetch_en=0; o_stall_cnt=1.
- i_load_use=1 and i_flush_req=1 same cycle -> o_id_flush=o_ex_flush=1, no stalls, fetch_en=1; o_flush_cnt=1, o_stall_cnt=0.
- i_dmem_busy=1 for 3 cycles with i_flush_req=1 -> all stalls=1, no flush for 3 cycles, then flush on cycle 4; o_stall_cnt=3, o_flush_cnt=1.
- i_id_valid=1, i_id_halt=1 -> DRAIN; o_id_flush=1; i_wb_halt after 3 cycles -> o_halted=1, o_state=3, o_trap=0; later i_flush_req has no effect.
- i_id_trap=1 enters DRAIN (o_trap=1), then i_flush_req=1 -> o_state=1, o_trap=0; counter preset near all-ones saturates at 2^CNT_W-1.
